// File: rtl/exc_pkg.sv
// exc_pkg: shared definitions for the exception controller.
// Holds the ExcCode values, the exc_src flag positions, the CP0 Status bit
// positions, the FSM state type, the default exception vector and the
// priority resolver used in the IDLE state.
// Optional feature macro used elsewhere in this slice: EXC_TIMER_EN.
package exc_pkg;

    // Redirect target for every exception other than ERET.
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'hBFC0_0380;

    // Cause.ExcCode values.
    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    // Bit positions inside exc_src; bits [1:0] carry nothing.
    localparam int SRC_ADEF = 7;
    localparam int SRC_SYS  = 6;
    localparam int SRC_BP   = 5;
    localparam int SRC_ERET = 4;
    localparam int SRC_RI   = 3;
    localparam int SRC_OV   = 2;

    // CP0 Status fields consulted for interrupt acceptance.
    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LSB = 8;

    // Controller FSM: IDLE resolves, COMMIT writes CP0, FLUSH redirects.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_FLUSH  = 2'd2
    } exc_state_e;

    // Outcome of one resolution attempt.
    typedef struct packed {
        logic       valid;         // some source is active
        logic       is_eret;       // winner is ERET (no CP0 write)
        logic       badv_we;       // winner is AdEL/AdES
        logic       badv_from_pc;  // BadVAddr comes from the fetch PC
        logic [4:0] code;          // ExcCode for non-ERET winners
    } exc_res_t;

    // Fixed-priority pick among all sources, highest first:
    // Int, AdEL (fetch or load), AdES, Sys, Bp, ERET, RI, Ov.
    function automatic exc_res_t exc_resolve(
        input logic       int_pend,
        input logic [7:0] src,
        input logic       err_l,
        input logic       err_s
    );
        exc_res_t r;
        r       = '0;
        r.valid = 1'b1;
        if (int_pend) begin
            r.code = EXC_INT;
        end else if (src[SRC_ADEF] || err_l) begin
            r.code         = EXC_ADEL;
            r.badv_we      = 1'b1;
            // A bad fetch address is the earlier fault, so it names BadVAddr.
            r.badv_from_pc = src[SRC_ADEF];
        end else if (err_s) begin
            r.code    = EXC_ADES;
            r.badv_we = 1'b1;
        end else if (src[SRC_SYS]) begin
            r.code = EXC_SYS;
        end else if (src[SRC_BP]) begin
            r.code = EXC_BP;
        end else if (src[SRC_ERET]) begin
            r.is_eret = 1'b1;
        end else if (src[SRC_RI]) begin
            r.code = EXC_RI;
        end else if (src[SRC_OV]) begin
            r.code = EXC_OV;
        end else begin
            r.valid = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/exception_ctrl_if.sv
// exception_ctrl_if: MEM-stage / CP0 side of the exception controller.
// With EXC_TIMER_EN defined the Count/Compare timer signals are added.
interface exception_ctrl_if
    import exc_pkg::*;
#(
    parameter int N_IRQ = 6
);

    // Handshake: mem_valid offers the MEM-stage instruction; the controller
    // consumes it only on a clock edge where stall_req is low (IDLE). While
    // stall_req is high the pipeline holds IF..MEM and anything offered on
    // mem_valid is not consumed, so it must be presented again afterwards.
    logic             mem_valid;
    logic [7:0]       exc_src;
    logic             addr_err_l;
    logic             addr_err_s;
    logic             in_delay_slot;
    logic [31:0]      inst_pc;
    logic [31:0]      bad_addr;
    logic [N_IRQ-1:0] hw_int;
    logic [31:0]      cp0_status;
    logic [1:0]       cp0_cause_ip_sw;
    logic [31:0]      cp0_epc;

    logic             stall_req;
    logic             flush;
    logic [31:0]      redirect_pc;
    logic             cp0_we;
    logic [4:0]       exc_code;
    logic [31:0]      epc_out;
    logic             bd_out;
    logic             badvaddr_we;
    logic [31:0]      badvaddr_out;
    logic             eret_commit;
    logic [N_IRQ-1:0] ip_hw;
    exc_state_e       dbg_state;

`ifdef EXC_TIMER_EN
    logic [31:0]      count_out;
    logic             compare_we;
    logic [31:0]      compare_wdata;
`endif

    // Pipeline / CP0 side.
    modport master (
        output mem_valid, exc_src, addr_err_l, addr_err_s, in_delay_slot,
               inst_pc, bad_addr, hw_int, cp0_status, cp0_cause_ip_sw, cp0_epc,
        input  stall_req, flush, redirect_pc, cp0_we, exc_code, epc_out, bd_out,
               badvaddr_we, badvaddr_out, eret_commit, ip_hw, dbg_state
`ifdef EXC_TIMER_EN
        , output compare_we, compare_wdata
        , input  count_out
`endif
    );

    // Exception controller side.
    modport slave (
        input  mem_valid, exc_src, addr_err_l, addr_err_s, in_delay_slot,
               inst_pc, bad_addr, hw_int, cp0_status, cp0_cause_ip_sw, cp0_epc,
        output stall_req, flush, redirect_pc, cp0_we, exc_code, epc_out, bd_out,
               badvaddr_we, badvaddr_out, eret_commit, ip_hw, dbg_state
`ifdef EXC_TIMER_EN
        , input  compare_we, compare_wdata
        , output count_out
`endif
    );

endinterface

// File: rtl/exc_sync.sv
// exc_sync: WIDTH-bit two-flop synchroniser with asynchronous active-low
// reset. q_o is the second flop.
module exc_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two stages so a metastable first flop has a full cycle to settle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/exception_ctrl.sv
// exception_ctrl: resolves MEM-stage exceptions and interrupts, commits the
// winner to CP0 for one cycle, then flushes the pipeline for FLUSH_CYCLES
// cycles while redirecting fetch to the exception vector (or EPC for ERET).
// Optional feature: define EXC_TIMER_EN to add the Count/Compare timer that
// raises IP7 (hardware line 5).
module exception_ctrl
    import exc_pkg::*;
#(
    parameter int          N_IRQ        = 6,
    parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            resetn,
    exception_ctrl_if.slave bus
);

    // Counter value loaded on COMMIT->FLUSH; FLUSH ends when it reaches zero.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    exc_state_e       state_q;
    exc_state_e       state_d;
    logic [2:0]       cnt_q;
    logic [2:0]       cnt_d;
    logic             run_q;

    logic [N_IRQ-1:0] sync_hw;
    logic [N_IRQ-1:0] ip_hw;
    logic             timer_irq;
    logic [5:0]       timer_mask;
    logic [7:0]       ip_all;
    logic             int_pend;
    exc_res_t         res;
    logic             fire;

    // Fields captured at the resolving edge (and redirect at COMMIT).
    logic [4:0]       code_q;
    logic [31:0]      epc_q;
    logic             bd_q;
    logic [31:0]      badv_q;
    logic             badv_we_q;
    logic             eret_q;
    logic [31:0]      redirect_q;

    logic             unused_bits;

    exc_sync #(
        .WIDTH (N_IRQ)
    ) u_sync (
        .clk_i  (clk),
        .rst_ni (resetn),
        .d_i    (bus.hw_int),
        .q_o    (sync_hw)
    );

`ifdef EXC_TIMER_EN
    logic        tick_q;
    logic [31:0] count_q;
    logic [31:0] count_inc;
    logic [31:0] compare_q;
    logic        timer_q;

    assign count_inc = count_q + 32'd1;

    // Count advances every second clock. The match is tested only on an
    // advance, so Compare=0 out of reset does not fire before Count wraps.
    // A Compare write clears the sticky request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick_q    <= 1'b0;
            count_q   <= '0;
            compare_q <= '0;
            timer_q   <= 1'b0;
        end else begin
            tick_q <= ~tick_q;
            if (tick_q) begin
                count_q <= count_inc;
            end
            if (bus.compare_we) begin
                compare_q <= bus.compare_wdata;
                timer_q   <= 1'b0;
            end else if (tick_q && (count_inc == compare_q)) begin
                timer_q <= 1'b1;
            end
        end
    end

    assign timer_irq     = timer_q;
    assign bus.count_out = count_q;
`else
    assign timer_irq = 1'b0;
`endif

    // The timer joins hardware line 5 after synchronisation (IP7).
    assign timer_mask = {timer_irq, 5'b0_0000};
    assign ip_hw      = sync_hw | timer_mask[N_IRQ-1:0];

    // Build the Cause.IP view and test it against Status.IM / EXL / IE.
    always_comb begin
        ip_all                 = 8'h00;
        ip_all[2 +: N_IRQ]     = ip_hw;
        ip_all[1:0]            = bus.cp0_cause_ip_sw;
        int_pend = ((ip_all & bus.cp0_status[STATUS_IM_LSB +: 8]) != 8'h00)
                   && !bus.cp0_status[STATUS_EXL]
                   && bus.cp0_status[STATUS_IE];
    end

    // Pick the highest-priority active source for the MEM-stage instruction.
    always_comb begin
        res  = exc_resolve(int_pend, bus.exc_src, bus.addr_err_l, bus.addr_err_s);
        fire = (state_q == ST_IDLE) && run_q && bus.mem_valid && res.valid;
    end

    // Reset release is retimed: resolution is held off until one edge after
    // resetn rises, so the first possible resolving edge is the second one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // FSM state and flush counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: IDLE -> COMMIT on a resolution, one COMMIT cycle, then
    // FLUSH until the down-counter has expired.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_d = ST_FLUSH;
                cnt_d   = FLUSH_LOAD;
            end
            ST_FLUSH: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Capture the resolved event on the resolving edge; capture the redirect
    // target at the end of COMMIT so ERET uses the EPC seen during COMMIT.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            code_q     <= 5'd0;
            epc_q      <= '0;
            bd_q       <= 1'b0;
            badv_q     <= '0;
            badv_we_q  <= 1'b0;
            eret_q     <= 1'b0;
            redirect_q <= '0;
        end else begin
            if (fire) begin
                code_q    <= res.code;
                epc_q     <= bus.in_delay_slot ? (bus.inst_pc - 32'd4) : bus.inst_pc;
                bd_q      <= bus.in_delay_slot;
                badv_q    <= res.badv_from_pc ? bus.inst_pc : bus.bad_addr;
                badv_we_q <= res.badv_we;
                eret_q    <= res.is_eret;
            end
            if (state_q == ST_COMMIT) begin
                redirect_q <= eret_q ? bus.cp0_epc : EXC_VECTOR;
            end
        end
    end

    // Outputs decode from state; every field is zero outside its own phase.
    always_comb begin
        bus.stall_req    = (state_q != ST_IDLE);
        bus.flush        = 1'b0;
        bus.redirect_pc  = '0;
        bus.cp0_we       = 1'b0;
        bus.exc_code     = 5'd0;
        bus.epc_out      = '0;
        bus.bd_out       = 1'b0;
        bus.badvaddr_we  = 1'b0;
        bus.badvaddr_out = '0;
        bus.eret_commit  = 1'b0;
        if (state_q == ST_COMMIT) begin
            bus.eret_commit = eret_q;
            if (!eret_q) begin
                bus.cp0_we       = 1'b1;
                bus.exc_code     = code_q;
                bus.epc_out      = epc_q;
                bus.bd_out       = bd_q;
                bus.badvaddr_we  = badv_we_q;
                bus.badvaddr_out = badv_q;
            end
        end
        if (state_q == ST_FLUSH) begin
            bus.flush       = 1'b1;
            bus.redirect_pc = redirect_q;
        end
    end

    assign bus.ip_hw     = ip_hw;
    assign bus.dbg_state = state_q;

    // Status bits other than IE/EXL/IM and the spare exc_src bits are not used.
    assign unused_bits = ^{bus.cp0_status[31:16], bus.cp0_status[7:2], bus.exc_src[1:0]};

endmodule

// File: tb/tb_exception_ctrl.sv
`timescale 1ns/1ps
// tb_exception_ctrl: directed and randomized checks of exception_ctrl
// against a behavioural priority model.
module tb_exception_ctrl;
    import exc_pkg::*;

    localparam int          N_IRQ        = 6;
    localparam int          FLUSH_CYCLES = 2;
    localparam logic [31:0] VEC          = 32'hBFC0_0380;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q[$];

    exception_ctrl_if #(.N_IRQ(N_IRQ)) bus ();

    exception_ctrl #(
        .N_IRQ        (N_IRQ),
        .EXC_VECTOR   (VEC),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  src;
        logic        err_l;
        logic        err_s;
        logic        bd;
        logic [31:0] pc;
        logic [31:0] badaddr;
        logic [31:0] status;
        logic [31:0] epc;
        logic [1:0]  sw;
        logic [5:0]  hw;
    } txn_t;

    typedef struct {
        bit          fire;
        bit          eret;
        logic [4:0]  code;
        logic [31:0] epc;
        bit          bd;
        bit          badv_we;
        logic [31:0] badv;
        logic [31:0] redirect;
    } exp_t;

    function automatic txn_t blank();
        txn_t t;
        t.src = 8'h00; t.err_l = 1'b0; t.err_s = 1'b0; t.bd = 1'b0;
        t.pc = '0; t.badaddr = '0; t.status = '0; t.epc = '0;
        t.sw = 2'b00; t.hw = 6'b0;
        return t;
    endfunction

    // Reference model: walk the priority list and take the first active entry.
    function automatic exp_t model(input txn_t t);
        exp_t e;
        logic [7:0] ip;
        bit ipend;
        bit act[8];
        int code[8];
        e.fire = 0; e.eret = 0; e.code = 5'd0; e.bd = t.bd; e.badv_we = 0;
        e.badv = t.badaddr; e.redirect = VEC;
        e.epc = t.bd ? t.pc - 32'd4 : t.pc;
        ip = {t.hw, t.sw};
        ipend = ((ip & t.status[15:8]) != 8'h00) && t.status[0] && !t.status[1];
        act  = '{ipend, t.src[7] | t.err_l, t.err_s, t.src[6], t.src[5], t.src[4], t.src[3], t.src[2]};
        code = '{0, 4, 5, 8, 9, -1, 10, 12};
        for (int i = 0; i < 8; i++) begin
            if (act[i] && !e.fire) begin
                e.fire = 1;
                e.eret = (code[i] < 0);
                e.code = e.eret ? 5'd0 : 5'(code[i]);
                e.badv_we = (code[i] == 4) || (code[i] == 5);
                if (code[i] == 4 && t.src[7]) e.badv = t.pc;
            end
        end
        if (e.eret) e.redirect = t.epc;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic idle_inputs();
        bus.mem_valid = 1'b0; bus.exc_src = 8'h00; bus.addr_err_l = 1'b0;
        bus.addr_err_s = 1'b0; bus.in_delay_slot = 1'b0;
    endtask

    task automatic drive(input txn_t t);
        bus.exc_src = t.src; bus.addr_err_l = t.err_l; bus.addr_err_s = t.err_s;
        bus.in_delay_slot = t.bd; bus.inst_pc = t.pc; bus.bad_addr = t.badaddr;
        bus.cp0_status = t.status; bus.cp0_cause_ip_sw = t.sw;
        bus.cp0_epc = ~t.epc;
        bus.mem_valid = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " stall"}, 32'(bus.stall_req), 32'd0);
        chk({tag, " flush"}, 32'(bus.flush), 32'd0);
        chk({tag, " redirect"}, bus.redirect_pc, 32'd0);
        chk({tag, " cp0_we"}, 32'(bus.cp0_we), 32'd0);
        chk({tag, " code"}, 32'(bus.exc_code), 32'd0);
        chk({tag, " epc"}, bus.epc_out, 32'd0);
        chk({tag, " bd"}, 32'(bus.bd_out), 32'd0);
        chk({tag, " badv_we"}, 32'(bus.badvaddr_we), 32'd0);
        chk({tag, " badv"}, bus.badvaddr_out, 32'd0);
        chk({tag, " eret"}, 32'(bus.eret_commit), 32'd0);
        chk({tag, " ip_hw"}, 32'(bus.ip_hw), 32'd0);
    endtask

    // Starts just after the negedge where t was driven; ends on the negedge
    // of the first IDLE cycle after the flush.
    task automatic check_seq(input string tag, input txn_t t);
        exp_t e;
        e = model(t);
        @(negedge clk);
        bus.mem_valid = 1'b0;
        if (!e.fire) begin
            chk({tag, " no-event stall"}, 32'(bus.stall_req), 32'd0);
            chk({tag, " no-event cp0_we"}, 32'(bus.cp0_we), 32'd0);
            return;
        end
        chk({tag, " commit stall"}, 32'(bus.stall_req), 32'd1);
        chk({tag, " commit cp0_we"}, 32'(bus.cp0_we), 32'(!e.eret));
        chk({tag, " commit eret"}, 32'(bus.eret_commit), 32'(e.eret));
        chk({tag, " commit flush"}, 32'(bus.flush), 32'd0);
        if (!e.eret) begin
            chk({tag, " code"}, 32'(bus.exc_code), 32'(e.code));
            chk({tag, " epc"}, bus.epc_out, e.epc);
            chk({tag, " bd"}, 32'(bus.bd_out), 32'(e.bd));
            chk({tag, " badv_we"}, 32'(bus.badvaddr_we), 32'(e.badv_we));
            chk({tag, " badv"}, bus.badvaddr_out, e.badv);
        end
        // Only the EPC present during COMMIT may be captured.
        bus.cp0_epc = t.epc;
        for (int i = 0; i < FLUSH_CYCLES; i++) exp_q.push_back(e.redirect);
        for (int i = 0; i < FLUSH_CYCLES; i++) begin
            @(negedge clk);
            bus.cp0_epc = ~t.epc;
            chk({tag, " flush"}, 32'(bus.flush), 32'd1);
            chk({tag, " redirect"}, bus.redirect_pc, exp_q.pop_front());
            chk({tag, " flush cp0_we"}, 32'(bus.cp0_we), 32'd0);
            chk({tag, " flush stall"}, 32'(bus.stall_req), 32'd1);
        end
        @(negedge clk);
        chk({tag, " end flush"}, 32'(bus.flush), 32'd0);
        chk({tag, " end stall"}, 32'(bus.stall_req), 32'd0);
        chk({tag, " end redirect"}, bus.redirect_pc, 32'd0);
    endtask

    task automatic do_txn(input string tag, input txn_t t);
        drive(t);
        check_seq(tag, t);
    endtask

    // Stimulus: directed steps followed by randomized transactions.
    initial begin
        txn_t t;
        txn_t t2;
        resetn = 1'b0;
        idle_inputs();
        bus.inst_pc = '0; bus.bad_addr = '0; bus.hw_int = '0;
        bus.cp0_status = '0; bus.cp0_cause_ip_sw = 2'b00; bus.cp0_epc = '0;
`ifdef EXC_TIMER_EN
        bus.compare_we = 1'b0; bus.compare_wdata = '0;
`endif
        repeat (3) @(negedge clk);
        check_zero("reset");

        // Syscall presented at reset release: first edge ignored, second resolves.
        t = blank(); t.src[6] = 1'b1; t.pc = 32'h8000_0100;
        resetn = 1'b1;
        drive(t);
        @(negedge clk);
        chk("release edge1 stall", 32'(bus.stall_req), 32'd0);
        check_seq("syscall", t);

        // Load address error in a delay slot.
        t = blank(); t.err_l = 1'b1; t.bd = 1'b1; t.pc = 32'h8000_0204; t.badaddr = 32'h8000_0003;
        do_txn("adel_bd", t);

        // hw_int[0] pulse vs overflow: interrupt wins after two sync edges.
        t = blank(); t.src[2] = 1'b1; t.pc = 32'h8000_0300; t.status = 32'h0000_0401; t.hw = 6'b000001;
        bus.cp0_status = t.status;
        bus.hw_int = 6'b000001;
        @(negedge clk);
        chk("sync edge1 ip_hw", 32'(bus.ip_hw), 32'd0);
        @(negedge clk);
        chk("sync edge2 ip_hw", 32'(bus.ip_hw), 32'd1);
        bus.hw_int = 6'b000000;
        do_txn("int_vs_ov", t);

        // ERET redirects to the EPC seen during COMMIT.
        t = blank(); t.src[4] = 1'b1; t.pc = 32'h8000_0400; t.epc = 32'h8000_1000;
        do_txn("eret", t);

        // Nothing active: no event.
        t = blank(); t.pc = 32'h8000_0500; t.status = 32'h0000_FF01;
        do_txn("none", t);

        // EXL masks a pending software interrupt; RI then wins.
        t = blank(); t.src[3] = 1'b1; t.status = 32'h0000_0103; t.sw = 2'b01; t.pc = 32'h8000_0600;
        do_txn("exl_mask", t);

        // Fetch error beats store error; BadVAddr is the fetch PC.
        t = blank(); t.src[7] = 1'b1; t.err_s = 1'b1; t.pc = 32'h8000_0702; t.badaddr = 32'h1234_5679;
        do_txn("adef_ades", t);

        // Second syscall during FLUSH is ignored until IDLE.
        t = blank(); t.src[6] = 1'b1; t.pc = 32'h8000_0800;
        drive(t);
        @(negedge clk);
        chk("busy first epc", bus.epc_out, 32'h8000_0800);
        bus.inst_pc = 32'h8000_0900;
        for (int i = 0; i < FLUSH_CYCLES; i++) begin
            @(negedge clk);
            chk("busy flush stall", 32'(bus.stall_req), 32'd1);
            chk("busy flush cp0_we", 32'(bus.cp0_we), 32'd0);
        end
        @(negedge clk);
        chk("busy idle stall", 32'(bus.stall_req), 32'd0);
        @(negedge clk);
        chk("busy second cp0_we", 32'(bus.cp0_we), 32'd1);
        chk("busy second epc", bus.epc_out, 32'h8000_0900);
        bus.mem_valid = 1'b0;
        repeat (FLUSH_CYCLES + 1) @(negedge clk);
        chk("busy drained stall", 32'(bus.stall_req), 32'd0);

        // Reset asserted during COMMIT clears everything at once.
        t = blank(); t.src[6] = 1'b1; t.pc = 32'h8000_0A00;
        drive(t);
        @(negedge clk);
        chk("pre-reset cp0_we", 32'(bus.cp0_we), 32'd1);
        resetn = 1'b0;
        #1;
        check_zero("reset in commit");
        idle_inputs();
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post-reset cp0_we", 32'(bus.cp0_we), 32'd0);
            chk("post-reset flush", 32'(bus.flush), 32'd0);
        end

        // Randomized transactions.
        for (int n = 0; n < 40; n++) begin
            t2 = blank();
            for (int b = 2; b < 8; b++) t2.src[b] = ($urandom_range(0, 3) == 0);
            t2.src[1:0] = 2'($urandom_range(0, 3));
            t2.err_l = ($urandom_range(0, 5) == 0);
            t2.err_s = ($urandom_range(0, 5) == 0);
            t2.bd = 1'($urandom_range(0, 1));
            t2.pc = $urandom();
            t2.badaddr = $urandom();
            t2.epc = $urandom();
            t2.status = $urandom();
            t2.status[1] = ($urandom_range(0, 3) == 0);
            t2.sw = ($urandom_range(0, 2) == 0) ? 2'($urandom()) : 2'b00;
            t2.hw = ($urandom_range(0, 2) == 0) ? 6'($urandom()) : 6'b0;
            bus.hw_int = t2.hw;
            repeat (2) @(negedge clk);
            chk("rand ip_hw", 32'(bus.ip_hw), 32'(t2.hw));
            do_txn("rand", t2);
        end

        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exception_ctrl.md
EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 Parameter N_IRQ, default 6: number of hardware interrupt lines, legal range 1..6, mapped to Cause.IP[2+:N_IRQ].
REQ-002 Parameter EXC_VECTOR, default 32'hBFC0_0380: redirect target for every non-ERET exception.
REQ-003 Parameter FLUSH_CYCLES, default 2: flush pulse length, legal range 1..7.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 resetn  in  1  asynchronous active-low reset.
REQ-006 mem_valid  in  1  MEM-stage instruction valid this cycle.
REQ-007 exc_src  in  8  per-instruction flags: [7] fetch address error, [6] syscall, [5] break, [4] eret, [3] reserved instruction, [2] overflow, [1:0] unused.
REQ-008 addr_err_l / addr_err_s  in  1 each  load / store address error.
REQ-009 in_delay_slot  in  1; inst_pc  in  32; bad_addr  in  32 (data address of the faulting load/store).
REQ-010 hw_int  in  N_IRQ  asynchronous interrupt requests.
REQ-011 cp0_status, cp0_cause_ip_sw, cp0_epc  in  32 / 2 / 32  current CP0 values.
REQ-012 stall_req  out  1  freezes IF..MEM while busy.
REQ-013 flush  out  1; redirect_pc  out  32.
REQ-014 cp0_we  out  1; exc_code  out  5; epc_out  out  32; bd_out  out  1; badvaddr_we  out  1; badvaddr_out  out  32; eret_commit  out  1; ip_hw  out  N_IRQ (synchronised interrupt lines, written into Cause).

Function
REQ-015 hw_int passes through a 2-flop synchroniser; ip_hw is the second flop.
REQ-016 Interrupt pending = ((ip_hw, cp0_cause_ip_sw) & Status.IM) != 0 with Status.EXL=0 and Status.IE=1.
REQ-017 Resolution priority, highest first: Int 0x00, fetch-error or addr_err_l AdEL 0x04, AdES 0x05, Sys 0x08, Bp 0x09, ERET, RI 0x0a, Ov 0x0c.
REQ-018 Resolution occurs only in IDLE with mem_valid=1; if no source is active, nothing happens.
REQ-019 FSM states: IDLE, COMMIT, FLUSH.
REQ-020 IDLE->COMMIT on a resolved event; the code, PC, BD and bad address are registered in the same edge.
REQ-021 COMMIT lasts exactly 1 cycle.
REQ-022 COMMIT outputs, non-ERET: cp0_we=1, exc_code, bd_out, epc_out = inst_pc-4 if BD else inst_pc.
REQ-023 COMMIT outputs, ERET: eret_commit=1, cp0_we=0.
REQ-024 badvaddr_we=1 in COMMIT only for AdEL/AdES. badvaddr_out = inst_pc for a fetch error, bad_addr otherwise.
REQ-025 COMMIT->FLUSH. flush=1 for exactly FLUSH_CYCLES cycles, counted by a 3-bit down-counter. Then FLUSH->IDLE.
REQ-026 redirect_pc is valid whenever flush=1: EXC_VECTOR, or cp0_epc sampled at the COMMIT cycle for ERET.
REQ-027 stall_req=1 in COMMIT and FLUSH. New mem_valid and interrupts are ignored there; pending interrupts are re-evaluated in the first IDLE cycle.
REQ-028 Latency from the resolving edge to the first flush cycle is 2 edges; ERET and exceptions are identical in timing.
REQ-029 Simultaneous interrupt and exception: the interrupt wins. EPC = faulting instruction PC; the instruction is re-executed after the handler.

Reset
REQ-030 Asynchronous assertion of resetn=0 returns the FSM to IDLE and clears the counter, the synchronisers, all registered fields and all outputs to 0, including redirect_pc.
REQ-031 Reset mid-COMMIT or mid-FLUSH aborts the sequence; no CP0 write completes after resetn rises.
REQ-032 Reset release is synchronous to clk through internal logic; the first resolution is possible on the second edge after deassertion.

Configuration
REQ-033 Macro EXC_TIMER_EN.
REQ-034 Defined: an internal 32-bit Count increments every second cycle, with ports count_out out 32, compare_we in 1, compare_wdata in 32.
REQ-035 Defined: Count==Compare sets a sticky timer interrupt on IP7 (hardware line 5, OR-ed after synchronisation); a compare_we write clears it.
REQ-036 Undefined: those ports, Count and the timer source are absent; IP7 is driven by hw_int only.

Structure
REQ-037 Shared package exc_pkg holds the ExcCode constants, the exc_src bit-index constants, the FSM state enum and the default vector.
REQ-038 One sub-module, exc_sync: an N-bit 2-flop synchroniser with async active-low reset.

Verification
REQ-039 Syscall at inst_pc=0x8000_0100, not in a delay slot -> COMMIT exc_code=0x08, epc_out=0x8000_0100; flush for 2 cycles with redirect_pc=0xBFC0_0380.
REQ-040 Load address error at bad_addr=0x8000_0003, in_delay_slot=1, inst_pc=0x8000_0204 -> exc_code=0x04, bd_out=1, epc_out=0x8000_0200, badvaddr_out=0x8000_0003.
REQ-041 hw_int[0] pulse with IM2=1, IE=1, EXL=0, plus overflow on the same instruction -> interrupt wins: exc_code=0x00, 2-cycle synchroniser delay observed.
REQ-042 ERET with cp0_epc=0x8000_1000 -> eret_commit=1, cp0_we=0, redirect_pc=0x8000_1000.
REQ-043 Second syscall presented during FLUSH -> ignored; stall_req stays high; resolved only after the return to IDLE.
REQ-044 resetn dropped in the COMMIT cycle -> all outputs 0 immediately; with EXC_TIMER_EN, Compare=10 after reset -> IP7 set at cycle 20.
